// File: rtl/psram_dev_resp.sv
// Octal-DDR PSRAM device responder: oversamples the host SCK/CE/IO/DQS link with clk_i
// and serves array and mode-register bursts from local storage.
module psram_dev_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [7:0]  RD_CMD     = 8'hEB,
    parameter logic [7:0]  WR_CMD     = 8'h38,
    parameter logic [7:0]  MRR_CMD    = 8'h40,
    parameter logic [7:0]  MRW_CMD    = 8'hC0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            rlc_i,
    input  logic [7:0]            wlc_i,
    input  logic                  psram_sck_i,
    input  logic                  psram_ce_i,
    input  logic [7:0]            psram_io_in_i,
    output logic [7:0]            psram_io_out_o,
    output logic                  psram_io_en_o,
    input  logic                  psram_dqs_in_i,
    output logic                  psram_dqs_out_o,
    output logic                  psram_dqs_en_o,
    output logic                  err_o,
    input  logic [DEPTH_LOG2-1:0] bd_addr_i,
    output logic [7:0]            bd_data_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INST     = 3'd1,
        ST_INST_DUP = 3'd2,
        ST_ADDR     = 3'd3,
        ST_LATN     = 3'd4,
        ST_RDATA    = 3'd5,
        ST_WDATA    = 3'd6,
        ST_WAIT     = 3'd7
    } state_t;

    state_t      state_r, state_s;
    logic        sck_q_r, ce_q_r;
    logic        edge_s, rise_s;
    logic [31:0] addr_r, addr_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [1:0]  acnt_r, acnt_s;
    logic        is_rd_r, is_rd_s;
    logic        is_mr_r, is_mr_s;
    logic        prime_r, prime_s;
    logic [7:0]  io_out_r, io_out_s;
    logic        io_en_r, io_en_s;
    logic        dqs_out_r, dqs_out_s;
    logic        dqs_en_r, dqs_en_s;
    logic        err_r, err_s;
    logic        wr_edge_s;
    logic        mem_we_s, mr_we_s;
    logic [7:0]  rd_byte_s;
    logic [7:0]  mem_r  [DEPTH];
    logic [7:0]  mode_r [8];

    // Any SCK level change is a DDR edge; only rises pace the latency counter.
    assign edge_s = psram_sck_i ^ sck_q_r;
    assign rise_s = psram_sck_i & ~sck_q_r;

    assign rd_byte_s = is_mr_r ? mode_r[addr_r[2:0]] : mem_r[addr_r[DEPTH_LOG2-1:0]];
    assign mem_we_s  = wr_edge_s & psram_dqs_in_i & ~is_mr_r & ~rst_i;
    assign mr_we_s   = wr_edge_s & psram_dqs_in_i & is_mr_r;
    assign bd_data_o = mem_r[bd_addr_i];

    assign psram_io_out_o  = io_out_r;
    assign psram_io_en_o   = io_en_r;
    assign psram_dqs_out_o = dqs_out_r;
    assign psram_dqs_en_o  = dqs_en_r;
    assign err_o           = err_r;

    // Next-state and next-output decode of the link protocol.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        acnt_s    = acnt_r;
        is_rd_s   = is_rd_r;
        is_mr_s   = is_mr_r;
        prime_s   = 1'b0;
        io_out_s  = io_out_r;
        io_en_s   = io_en_r;
        dqs_out_s = dqs_out_r;
        dqs_en_s  = dqs_en_r;
        err_s     = 1'b0;
        wr_edge_s = 1'b0;
        if (psram_ce_i) begin
            // CE deassertion beats any coincident SCK edge and drops partial context.
            state_s   = ST_IDLE;
            io_out_s  = 8'h00;
            io_en_s   = 1'b0;
            dqs_out_s = 1'b0;
            dqs_en_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ce_q_r) begin
                        state_s = ST_INST;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_INST: begin
                    if (edge_s) begin
                        case (psram_io_in_i)
                            RD_CMD:  begin is_rd_s = 1'b1; is_mr_s = 1'b0; state_s = ST_INST_DUP; end
                            WR_CMD:  begin is_rd_s = 1'b0; is_mr_s = 1'b0; state_s = ST_INST_DUP; end
                            MRR_CMD: begin is_rd_s = 1'b1; is_mr_s = 1'b1; state_s = ST_INST_DUP; end
                            MRW_CMD: begin is_rd_s = 1'b0; is_mr_s = 1'b1; state_s = ST_INST_DUP; end
                            default: begin err_s = 1'b1; state_s = ST_WAIT; end
                        endcase
                    end else begin
                        state_s = ST_INST;
                    end
                end
                ST_INST_DUP: begin
                    if (edge_s) begin
                        acnt_s  = 2'd0;
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_INST_DUP;
                    end
                end
                ST_ADDR: begin
                    if (edge_s) begin
                        addr_s = {addr_r[23:0], psram_io_in_i};
                        acnt_s = acnt_r + 2'd1;
                        if (acnt_r == 2'd3) begin
                            state_s = ST_LATN;
                            cnt_s   = is_rd_r ? rlc_i : wlc_i;
                        end else begin
                            state_s = ST_ADDR;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_LATN: begin
                    if (rise_s) begin
                        if (cnt_r == 8'd0) begin
                            // The exiting rise is itself the first data edge.
                            if (is_rd_r) begin
                                state_s   = ST_RDATA;
                                io_en_s   = 1'b1;
                                dqs_en_s  = 1'b1;
                                dqs_out_s = 1'b0;
                                prime_s   = 1'b1;
                            end else begin
                                state_s   = ST_WDATA;
                                wr_edge_s = 1'b1;
                                addr_s    = addr_r + 32'd1;
                            end
                        end else begin
                            cnt_s = cnt_r - 8'd1;
                        end
                    end else begin
                        state_s = ST_LATN;
                    end
                end
                ST_RDATA: begin
                    if (prime_r || edge_s) begin
                        io_out_s  = rd_byte_s;
                        dqs_out_s = ~dqs_out_r;
                        addr_s    = addr_r + 32'd1;
                    end else begin
                        state_s = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (edge_s) begin
                        wr_edge_s = 1'b1;
                        addr_s    = addr_r + 32'd1;
                    end else begin
                        state_s = ST_WDATA;
                    end
                end
                ST_WAIT: begin
                    state_s = ST_WAIT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Link sampling, FSM state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            sck_q_r   <= 1'b0;
            ce_q_r    <= 1'b1;
            addr_r    <= 32'd0;
            cnt_r     <= 8'd0;
            acnt_r    <= 2'd0;
            is_rd_r   <= 1'b0;
            is_mr_r   <= 1'b0;
            prime_r   <= 1'b0;
            io_out_r  <= 8'h00;
            io_en_r   <= 1'b0;
            dqs_out_r <= 1'b0;
            dqs_en_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            sck_q_r   <= psram_sck_i;
            ce_q_r    <= psram_ce_i;
            addr_r    <= addr_s;
            cnt_r     <= cnt_s;
            acnt_r    <= acnt_s;
            is_rd_r   <= is_rd_s;
            is_mr_r   <= is_mr_s;
            prime_r   <= prime_s;
            io_out_r  <= io_out_s;
            io_en_r   <= io_en_s;
            dqs_out_r <= dqs_out_s;
            dqs_en_r  <= dqs_en_s;
            err_r     <= err_s;
        end
    end

    // Byte array keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[addr_r[DEPTH_LOG2-1:0]] <= psram_io_in_i;
        end
    end

    // Mode-register file, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                mode_r[i] <= 8'h00;
            end
        end else if (mr_we_s) begin
            mode_r[addr_r[2:0]] <= psram_io_in_i;
        end
    end

endmodule

// File: tb/tb_psram_dev_resp.sv
// Scoreboard bench for psram_dev_resp: a host task bit-bangs the link, a reference model
// predicts array/mode contents and read bursts, and a monitor checks the responder output.
module tb_psram_dev_resp;

    localparam int DL    = 10;
    localparam int DEPTH = 1024;
    localparam logic [7:0] RD  = 8'hEB;
    localparam logic [7:0] WR  = 8'h38;
    localparam logic [7:0] MRR = 8'h40;
    localparam logic [7:0] MRW = 8'hC0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rlc = 8'd0;
    logic [7:0]    wlc = 8'd0;
    logic          sck = 1'b0;
    logic          ce = 1'b1;
    logic [7:0]    io_in = 8'h00;
    logic          dqs_in = 1'b0;
    logic [7:0]    io_out;
    logic          io_en, dqs_out, dqs_en, err;
    logic [DL-1:0] bd_addr = '0;
    logic [7:0]    bd_data;

    always #5 clk = ~clk;

    psram_dev_resp #(.DEPTH_LOG2(DL)) dut (
        .clk_i(clk), .rst_i(rst), .rlc_i(rlc), .wlc_i(wlc),
        .psram_sck_i(sck), .psram_ce_i(ce), .psram_io_in_i(io_in),
        .psram_io_out_o(io_out), .psram_io_en_o(io_en),
        .psram_dqs_in_i(dqs_in), .psram_dqs_out_o(dqs_out), .psram_dqs_en_o(dqs_en),
        .err_o(err), .bd_addr_i(bd_addr), .bd_data_o(bd_data)
    );

    int         n_checks = 0;
    int         n_err = 0;
    int         err_cnt = 0;
    bit         rd_window = 1'b0;
    logic [7:0] mem_m [DEPTH];
    logic [7:0] mode_m [8];
    logic [8:0] exp_q [$];
    logic [7:0] edge_io [$];
    logic       edge_dqs [$];
    logic [7:0] wd [$];
    logic       wm [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Edge list for instruction (sent twice), 4 address bytes and 2*lc dummy edges.
    task automatic hdr(input logic [7:0] cmd, input logic [31:0] a, input int lc);
        edge_io.delete();
        edge_dqs.delete();
        repeat (2) begin edge_io.push_back(cmd); edge_dqs.push_back(1'b0); end
        for (int i = 3; i >= 0; i--) begin
            edge_io.push_back(a[8*i +: 8]);
            edge_dqs.push_back(1'b0);
        end
        for (int i = 0; i < 2 * lc; i++) begin edge_io.push_back(8'h00); edge_dqs.push_back(1'b0); end
    endtask

    task automatic drive();
        @(negedge clk);
        ce = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < edge_io.size(); i++) begin
            io_in = edge_io[i];
            dqs_in = edge_dqs[i];
            sck = ~sck;
            repeat (4) @(negedge clk);
        end
        ce = 1'b1;
        sck = 1'b0;
        io_in = 8'h00;
        dqs_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Write burst of wd/wm; model applies masked bytes at (a+i) mod size.
    task automatic do_write(input bit mr, input logic [31:0] a, input int lc);
        logic [31:0] ai;
        wlc = 8'(lc);
        hdr(mr ? MRW : WR, a, lc);
        for (int i = 0; i < wd.size(); i++) begin
            edge_io.push_back(wd[i]);
            edge_dqs.push_back(wm[i]);
            ai = a + 32'(i);
            if (wm[i]) begin
                if (mr) mode_m[ai % 8] = wd[i];
                else    mem_m[ai % DEPTH] = wd[i];
            end
        end
        drive();
    endtask

    task automatic do_read(input bit mr, input logic [31:0] a, input int lc, input int n);
        logic [31:0] ai;
        rlc = 8'(lc);
        hdr(mr ? MRR : RD, a, lc);
        for (int i = 0; i < n; i++) begin
            edge_io.push_back(8'h00);
            edge_dqs.push_back(1'b0);
            ai = a + 32'(i);
            exp_q.push_back({(i % 2 == 0), (mr ? mode_m[ai % 8] : mem_m[ai % DEPTH])});
        end
        rd_window = 1'b1;
        drive();
        rd_window = 1'b0;
        check("rd_drained", exp_q.size(), 0);
    endtask

    task automatic bd_check(input string nm, input int a);
        bd_addr = DL'(a);
        #1;
        check(nm, bd_data, mem_m[a]);
    endtask

    // Monitor: one expected byte per DQS toggle while the responder drives IO.
    initial begin
        logic       prev_en;
        logic       prev_dqs;
        logic [8:0] e;
        prev_en = 1'b0;
        prev_dqs = 1'b0;
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
            if (io_en && !prev_en) check("io_en_window", 32'(rd_window), 32'd1);
            if (io_en && (dqs_out != prev_dqs)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rd_extra: got byte 0x%0h, expected none", io_out);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", io_out, e[7:0]);
                    check("rd_dqs", dqs_out, e[8]);
                end
            end
            prev_en = io_en;
            prev_dqs = io_en ? dqs_out : 1'b0;
        end
    end

    initial begin
        int   e0;
        int   bad;
        int   t;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) mode_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_io_out", io_out, 8'h00);
        check("rst_io_en", io_en, 1'b0);
        check("rst_dqs_out", dqs_out, 1'b0);
        check("rst_dqs_en", dqs_en, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wd.delete(); wm.delete();
        for (int i = 0; i < DEPTH; i++) begin wd.push_back(8'($urandom)); wm.push_back(1'b1); end
        do_write(1'b0, 32'd0, 0);

        wd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; wm = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_write(1'b0, 32'h10, 2);
        for (int i = 0; i < 4; i++) bd_check("wr_basic", 16 + i);

        wd = '{8'h11, 8'h22, 8'h33, 8'h44}; wm = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_write(1'b0, 32'h10, 2);
        for (int i = 0; i < 4; i++) bd_check("wr_masked", 16 + i);

        do_read(1'b0, 32'h10, 3, 4);

        wd = '{8'h5C, 8'hC5}; wm = '{1'b1, 1'b1};
        do_write(1'b0, 32'h3FF, 1);
        bd_check("wrap_hi", 32'h3FF);
        bd_check("wrap_lo", 0);

        e0 = err_cnt;
        hdr(WR, 32'h10, 0);
        while (edge_io.size() > 4) void'(edge_io.pop_back());
        drive();
        do_read(1'b0, 32'h10, 2, 4);
        check("abort_no_err", err_cnt, e0);

        e0 = err_cnt;
        hdr(8'h5A, 32'h10, 0);
        for (int i = 0; i < 4; i++) begin edge_io.push_back(8'hFF); edge_dqs.push_back(1'b1); end
        drive();
        check("bad_inst_err", err_cnt, e0 + 1);
        for (int i = 0; i < 4; i++) bd_check("bad_inst_nowr", 16 + i);

        wd = '{8'h7E}; wm = '{1'b1};
        do_write(1'b1, 32'd3, 1);
        do_read(1'b1, 32'd3, 1, 1);

        e0 = err_cnt;
        for (int k = 0; k < 30; k++) begin
            int cmd, lc, n;
            cmd = $urandom_range(0, 3);
            a = $urandom();
            lc = $urandom_range(0, 4);
            n = $urandom_range(1, 8);
            if (cmd == 0 || cmd == 2) begin
                wd.delete(); wm.delete();
                for (int i = 0; i < n; i++) begin
                    wd.push_back(8'($urandom));
                    wm.push_back(1'($urandom_range(0, 3) != 0));
                end
                do_write(cmd == 2, a, lc);
                if (cmd == 0) for (int i = 0; i < n; i++) bd_check("rand_wr", int'((a + 32'(i)) % DEPTH));
            end else begin
                do_read(cmd == 3, a, lc, n);
            end
        end
        check("rand_no_err", err_cnt, e0);

        rlc = 8'd1;
        hdr(RD, 32'h20, 1);
        for (int i = 0; i < 16; i++) begin
            edge_io.push_back(8'h00);
            edge_dqs.push_back(1'b0);
            exp_q.push_back({(i % 2 == 0), mem_m[32 + i]});
        end
        rd_window = 1'b1;
        fork
            drive();
            begin
                t = 0;
                while (!io_en && t < 400) begin @(negedge clk); t++; end
                if (!io_en) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rst_mid_read: io_en never rose within %0d clocks, expected 1", t);
                end
                repeat (6) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("mid_rst_io_out", io_out, 8'h00);
                check("mid_rst_io_en", io_en, 1'b0);
                check("mid_rst_dqs_out", dqs_out, 1'b0);
                check("mid_rst_dqs_en", dqs_en, 1'b0);
                check("mid_rst_err", err, 1'b0);
            end
        join
        rst = 1'b0;
        rd_window = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mode_m[i] = 8'h00;
        repeat (2) @(negedge clk);

        do_read(1'b1, 32'd0, 0, 8);
        do_read(1'b0, 32'h3FE, 2, 4);

        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bd_addr = DL'(i);
            #1;
            if (bd_data !== mem_m[i]) begin
                if (bad == 0) $display("FAIL bd_sweep: addr 0x%0h got 0x%0h, expected 0x%0h", i, bd_data, mem_m[i]);
                bad++;
            end
        end
        check("bd_sweep_count", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
